// File: rtl/dmem_pkg.sv
// Shared encodings and write-lane helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] WSIZE_B   = 2'b00;
    localparam logic [1:0] WSIZE_H   = 2'b01;
    localparam logic [1:0] WSIZE_W   = 2'b10;
    localparam logic [1:0] WSIZE_RSV = 2'b11;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } wr_lane_t;

    function automatic logic [3:0] wr_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            WSIZE_B: be = 4'b0001 << off;
            WSIZE_H: be = off[1] ? 4'b1100 : 4'b0011;
            WSIZE_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data is replicated so every enabled lane sees it.
    function automatic wr_lane_t wr_steer(input logic [1:0] size, input logic [1:0] off,
                                          input logic [31:0] data);
        wr_lane_t r;
        r.be = wr_be(size, off);
        case (size)
            WSIZE_B: r.data = {4{data[7:0]}};
            WSIZE_H: r.data = {2{data[15:0]}};
            default: r.data = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store bus between the execute unit (master) and dmem_ctrl (slave).
interface dmem_if;
    logic        mem_ren_i;
    logic [31:0] mem_raddr_i;
    logic [31:0] mem_rdata_o;
    logic        mem_wen_i;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [1:0]  mem_wsize_i;
    logic        busy_o;
    logic        err_o;
    logic        err_valid_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i;

    modport master (
        output mem_ren_i, mem_raddr_i, mem_wen_i, mem_waddr_i, mem_wdata_i, mem_wsize_i, err_clr_i,
        input  mem_rdata_o, busy_o, err_o, err_valid_o, err_addr_o
    );

    modport slave (
        input  mem_ren_i, mem_raddr_i, mem_wen_i, mem_waddr_i, mem_wdata_i, mem_wsize_i, err_clr_i,
        output mem_rdata_o, busy_o, err_o, err_valid_o, err_addr_o
    );
endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 RAM built from four byte-lane arrays; synchronous read and
// byte-enabled synchronous write, read-first on a same-address collision.
module dmem_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    localparam int DEPTH = 2 ** AW;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (we && wbe[gi]) begin
                    lane_mem[waddr] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    lane_rd_reg <= lane_mem[raddr];
                end
            end

            assign rdata[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: zero-fill FSM, store steering, access checks and error log.
// Define DMEM_WR_FWD_EN for write-first same-word read/write; default is read-first.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int AW = ADDR_W - 2;

    logic [0:0]    state_reg, state_next;
    logic [AW-1:0] init_cnt_reg, init_cnt_next;
    logic          run;

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        if (state_reg == ST_INIT) begin
            init_cnt_next = init_cnt_reg + 1'b1;
            if (init_cnt_reg == '1) begin
                state_next = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    assign run        = (state_reg == ST_RUN);
    assign bus.busy_o = (state_reg == ST_INIT);

    logic [AW-1:0] widx, ridx;
    logic          w_in_range, r_in_range, w_align_ok;
    logic          wr_req, rd_req, wr_bad, rd_bad, wr_ok;
    wr_lane_t      wr_lane;
    logic          unused_raddr_lsb;

    assign widx       = bus.mem_waddr_i[ADDR_W-1:2];
    assign ridx       = bus.mem_raddr_i[ADDR_W-1:2];
    assign w_in_range = (bus.mem_waddr_i >> ADDR_W) == 32'd0;
    assign r_in_range = (bus.mem_raddr_i >> ADDR_W) == 32'd0;
    // Reads are word-granular, so the byte offset of a read is irrelevant.
    assign unused_raddr_lsb = &{1'b0, bus.mem_raddr_i[1:0]};

    always_comb begin
        w_align_ok = 1'b1;
        case (bus.mem_wsize_i)
            WSIZE_H:   w_align_ok = ~bus.mem_waddr_i[0];
            WSIZE_W:   w_align_ok = (bus.mem_waddr_i[1:0] == 2'b00);
            WSIZE_RSV: w_align_ok = 1'b0;
            default:   w_align_ok = 1'b1;
        endcase
    end

    assign wr_req  = run && bus.mem_wen_i;
    assign rd_req  = run && bus.mem_ren_i;
    assign wr_bad  = wr_req && !(w_in_range && w_align_ok);
    assign rd_bad  = rd_req && !r_in_range;
    assign wr_ok   = wr_req && !wr_bad;
    assign wr_lane = wr_steer(bus.mem_wsize_i, bus.mem_waddr_i[1:0], bus.mem_wdata_i);

    // During INIT the write port is owned by the zero-fill counter.
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [3:0]    ram_wbe;
    logic [31:0]   ram_wdata, ram_rdata;

    assign ram_we    = run ? wr_ok : 1'b1;
    assign ram_waddr = run ? widx : init_cnt_reg;
    assign ram_wbe   = run ? wr_lane.be : 4'b1111;
    assign ram_wdata = run ? wr_lane.data : 32'd0;

    dmem_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wbe   (ram_wbe),
        .wdata (ram_wdata),
        .re    (rd_req),
        .raddr (ridx),
        .rdata (ram_rdata)
    );

    logic [31:0] lane_mask;
    logic        fwd_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign lane_mask[8*gi +: 8] = {8{wr_lane.be[gi]}};
        end
    endgenerate

`ifdef DMEM_WR_FWD_EN
    assign fwd_hit = wr_ok && (widx == ridx);
`else
    assign fwd_hit = 1'b0;
`endif

    // Output-side registers change only on an accepted read, so the word holds.
    logic        rd_zero_reg;
    logic [31:0] fwd_mask_reg, fwd_data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_zero_reg  <= 1'b1;
            fwd_mask_reg <= '0;
            fwd_data_reg <= '0;
        end else if (rd_req) begin
            rd_zero_reg  <= rd_bad;
            fwd_mask_reg <= fwd_hit ? lane_mask : 32'd0;
            fwd_data_reg <= wr_lane.data;
        end
    end

    assign bus.mem_rdata_o = rd_zero_reg ? 32'd0
                           : (ram_rdata & ~fwd_mask_reg) | (fwd_data_reg & fwd_mask_reg);

    logic        err_reg, err_valid_reg;
    logic [31:0] err_addr_reg;
    logic        err_any;
    logic [31:0] err_cap_addr;

    assign err_any      = wr_bad || rd_bad;
    assign err_cap_addr = wr_bad ? bus.mem_waddr_i : bus.mem_raddr_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg       <= 1'b0;
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            err_reg <= err_any;
            if (err_any && (!err_valid_reg || bus.err_clr_i)) begin
                err_valid_reg <= 1'b1;
                err_addr_reg  <= err_cap_addr;
            end else if (bus.err_clr_i) begin
                err_valid_reg <= 1'b0;
                err_addr_reg  <= '0;
            end
        end
    end

    assign bus.err_o       = err_reg;
    assign bus.err_valid_o = err_valid_reg;
    assign bus.err_addr_o  = err_addr_reg;
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the execute unit's load/store interface. It holds a byte-addressed, word-organised RAM and accepts byte, half-word and word stores with lane steering and byte enables. It returns raw 32-bit words for loads one cycle after the request; the execute unit performs lane selection and sign or zero extension. It zero-fills the array after reset, and it detects, flags and records illegal accesses.

## Interface
- `ADDR_W`, default 12: byte-address bits that are implemented. Word depth is `2**(ADDR_W-2)`, so the default gives 1024 words (4 KiB).
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst_n` in 1: reset. **Reset is synchronous and active-low.**
- `mem_ren_i` in 1: read request.
- `mem_raddr_i` in 32: read byte address.
- `mem_rdata_o` out 32: registered read word.
- `mem_wen_i` in 1: write request.
- `mem_waddr_i` in 32: write byte address.
- `mem_wdata_i` in 32: write data, right-aligned (byte in [7:0], half-word in [15:0]).
- `mem_wsize_i` in 2: write size. 00 byte, 01 half-word, 10 word, 11 reserved.
- `busy_o` out 1: high while the array is being initialised.
- `err_o` out 1: one-cycle pulse on an illegal access.
- `err_valid_o` out 1: sticky; an error has been recorded.
- `err_addr_o` out 32: address of the first recorded error.
- `err_clr_i` in 1: clears `err_valid_o` and `err_addr_o`.

## Operation
- **FSM states:** INIT and RUN.
  - Reset enters INIT with the init counter at 0.
  - In INIT, each cycle writes word[counter] = 0 and increments the counter.
  - After word DEPTH-1 is written, the next state is RUN.
  - `busy_o` = (state == INIT).
  - Reset asserted at any point, including mid-INIT, restarts INIT from 0.
- **Requests during INIT:** ignored. There is no write, `mem_rdata_o` holds its value, and no error is raised.
- **Word index:** `addr[ADDR_W-1:2]`.
- **Address range:** an address is in range iff `addr[31:ADDR_W] == 0`.
- **Write steering:**
  - Byte: be = 1 << addr[1:0]; the data byte is replicated to all lanes.
  - Half-word: be = addr[1] ? 1100 : 0011; the data half is replicated to both halves.
  - Word: be = 1111.
- **Illegal write:** size 11, half-word with addr[0] = 1, word with addr[1:0] != 0, or out of range. The write is suppressed; no bytes change.
- **Illegal read:** out of range only. A misaligned read is legal and returns the containing word. For an illegal read, `mem_rdata_o` is loaded with 0.
- **Error recording:**
  - Any illegal access pulses `err_o` on the following cycle.
  - If `err_valid_o` = 0, the block captures the address and sets `err_valid_o`.
  - If a read error and a write error occur in the same cycle, the write address is captured.
  - If `err_clr_i` and a new error occur in the same cycle, the new error is captured.
  - While `err_valid_o` = 1, later errors pulse `err_o` but do not overwrite the captured address.
- **Same-cycle read and write to the same word:** behaviour is set by the configuration macro (see Configuration).

## Timing
- **Reset values:**
  - `mem_rdata_o` = 0, `busy_o` = 1, `err_o` = 0, `err_valid_o` = 0, `err_addr_o` = 0.
  - State = INIT, counter = 0.
- **INIT duration:** exactly DEPTH cycles after the first cycle with `rst_n` = 1. `busy_o` falls in cycle DEPTH.
- **Write:** sampled at the edge of cycle t; array contents are visible to a read issued in cycle t+1.
- **Read:** issued in cycle t; `mem_rdata_o` is valid from cycle t+1 and holds until the next accepted read.
- **Error pulse:** `err_o` and the capture occur at the edge ending the request cycle, so both are visible in cycle t+1.
- **Throughput:** one read and one write are accepted every cycle in RUN; there is no backpressure.

## Configuration
- **`DMEM_WR_FWD_EN` defined:** write-first behaviour. A same-cycle legal write and read to the same word returns the old word merged with the new bytes under be.
- **`DMEM_WR_FWD_EN` undefined:** read-first behaviour. The read returns the old word.
- The write is committed identically in both builds.

## Structure
- **Shared package `dmem_pkg`** holds:
  - Size encodings WSIZE_B, WSIZE_H, WSIZE_W, WSIZE_RSV.
  - FSM state encodings ST_INIT and ST_RUN.
  - The byte-enable helper function.
- **Sub-module `dmem_ram`** provides:
  - A DEPTH×32 array.
  - A synchronous read port and a synchronous write port with a 4-bit byte enable.
  - No reset on the array itself.
- **`dmem_ctrl`** holds the FSM, steering, range and alignment checks, the forwarding mux and the error registers.

## Test plan
- **Init:** release reset, count cycles until `busy_o` falls (must be 1024); read 0x000, 0x7FC and 0x400 → all return 0.
- **Byte lanes:** SB 0xA1 to 0x101, SH 0xBEEF to 0x102, then read 0x100 → 0xBEEFA100. SW 0x12345678 to 0x100, then read → 0x12345678.
- **Misaligned write:**
  - SH to 0x201 → no change, `err_o` pulses, `err_addr_o` = 0x201, `err_valid_o` = 1.
  - SW to 0x302 next → `err_o` pulses again, `err_addr_o` stays 0x201.
  - `err_clr_i` → `err_valid_o` = 0, `err_addr_o` = 0.
- **Out of range:** read 0x1000 → `mem_rdata_o` = 0 and `err_addr_o` = 0x1000. Size-11 write to 0x10 → word unchanged.
- **Same-cycle RW:** word 0x40 = 0x11223344; SB 0xFF to 0x40 while reading 0x40.
  - With `DMEM_WR_FWD_EN` → 0x112233FF.
  - Without it → 0x11223344.
  - Either build, a following read → 0x112233FF.
- **Reset mid-INIT:** pulse `rst_n` low at INIT cycle 500 → `busy_o` stays high, and falls 1024 cycles after the release; writes during `busy_o` are ignored.
